// File: rtl/regfile_read_port_pkg.sv
// Shared register-bank geometry and the response entry layout for regfile_read_port.
// Used by the RTL and by the bench model.
package regfile_read_port_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
    } rsp_entry_t;

    // Address width for a bank of n registers, never narrower than one bit
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_read_port_rsp_fifo.sv
// Two-entry synchronous FIFO; head is a dedicated register, so the output holds its last value when empty.
// Push/pop same cycle keeps occupancy; push when full and pop when empty are ignored.
module regread_rsp_fifo #(
    parameter int DW = 37
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_head_dat,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic [DW-1:0] r_head;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic          w_push;
    logic          w_pop;

    assign o_full     = (r_count == 2'd2);
    assign o_empty    = (r_count == 2'd0);
    assign o_head_dat = r_head;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // Head follows the oldest surviving entry; an incoming word only lands
            // here when it becomes the oldest in the same cycle.
            if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_mem[~r_rd_ptr];
            end else if (w_push && ((r_count == 2'd0) || (w_pop && (r_count == 2'd1)))) begin
                r_head <= i_push_dat;
            end
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Register read port: request handshake -> bank read (reg0 = 0, optional write bypass under REGREAD_BYPASS_EN) -> 2-entry response FIFO.
// One-cycle latency, one read per cycle; req_ready = !full from registered state, so rsp_ready never reaches req_ready combinationally.
module regfile_read_port
    import regfile_read_port_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = REG_COUNT,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*NREGS-1:0] regs_flat,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [AW-1:0]          rsp_addr
);

    localparam int EW = AW + WIDTH;

    logic [WIDTH-1:0] w_rd_data;
    logic [EW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Loop starts at 1 so register 0 and out-of-range addresses fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (req_addr == AW'(i)) begin
                w_rd_data = regs_flat[i*WIDTH +: WIDTH];
            end
        end
`ifdef REGREAD_BYPASS_EN
        if (wr_en && (wr_addr == req_addr) && (wr_addr != '0) &&
            ({1'b0, req_addr} < (AW+1)'(NREGS))) begin
            w_rd_data = wr_data;
        end
`endif
    end

`ifndef REGREAD_BYPASS_EN
    logic w_unused_wr;
    assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    assign req_ready = !w_full;
    assign rsp_valid = !w_empty;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    regread_rsp_fifo #(
        .DW (EW)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat ({req_addr, w_rd_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign {rsp_addr, rsp_data} = w_head;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_read_port;
    import regfile_read_port_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic [REG_WIDTH*REG_COUNT-1:0]    regs_flat;
    logic                              wr_en;
    logic [REG_ADDR_W-1:0]             wr_addr;
    logic [REG_WIDTH-1:0]              wr_data;
    logic                              req_valid;
    logic                              req_ready;
    logic [REG_ADDR_W-1:0]             req_addr;
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [REG_WIDTH-1:0]              rsp_data;
    logic [REG_ADDR_W-1:0]             rsp_addr;

    logic [REG_WIDTH-1:0] bank [REG_COUNT];
    rsp_entry_t           q [$];
    rsp_entry_t           last;
    int                   n_checks = 0;
    int                   n_errors = 0;
    int                   n_pops   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) regs_flat[i*REG_WIDTH +: REG_WIDTH] = bank[i];
    end

    regfile_read_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs_flat (regs_flat),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value a register read should return given the bank and the write in flight this cycle
    function automatic logic [REG_WIDTH-1:0] ref_read(input logic [REG_ADDR_W-1:0] a);
        if (a == '0) return '0;
`ifdef REGREAD_BYPASS_EN
        if (wr_en && (wr_addr == a)) return wr_data;
`endif
        return bank[a];
    endfunction

    // Check outputs against the model, then advance one clock and update the model.
    task automatic step();
        logic       acc;
        logic       pop;
        rsp_entry_t e;
        chk("req_ready", {63'd0, req_ready}, {63'd0, q.size() < 2});
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rsp_data", {32'd0, rsp_data}, {32'd0, q[0].data});
            chk("rsp_addr", {59'd0, rsp_addr}, {59'd0, q[0].addr});
        end else begin
            chk("hold_data", {32'd0, rsp_data}, {32'd0, last.data});
            chk("hold_addr", {59'd0, rsp_addr}, {59'd0, last.addr});
        end
        acc    = req_valid && (q.size() < 2);
        pop    = (q.size() != 0) && rsp_ready;
        e.addr = req_addr;
        e.data = ref_read(req_addr);
        @(posedge clk);
        #1;
        if (pop) begin
            last = q.pop_front();
            n_pops++;
        end
        if (acc) q.push_back(e);
        if (wr_en) bank[wr_addr] = wr_data;
    endtask

    task automatic request(input logic [REG_ADDR_W-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
    endtask

    initial begin
        int pops0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        last      = '0;
        for (int i = 0; i < REG_COUNT; i++) bank[i] = '0;

        #12;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_data",  {32'd0, rsp_data},  64'd0);
        chk("rst_rsp_addr",  {59'd0, rsp_addr},  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic read and register-0 masking
        bank[5]   = 32'hDEADBEEF;
        bank[0]   = 32'hFFFFFFFF;
        rsp_ready = 1'b1;
        request(5);
        request(0);
        req_valid = 1'b0;
        step();
        step();
        chk("reg0_reads_zero", {32'd0, last.data}, 64'd0);

        // Backpressure: third request waits until a slot frees
        bank[1] = 32'h00000101;
        bank[2] = 32'h00000202;
        bank[3] = 32'h00000303;
        rsp_ready = 1'b0;
        request(1);
        request(2);
        request(3);
        step();
        step();
        rsp_ready = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("backpressure_last", {59'd0, last.addr}, 64'd3);

        // Same-cycle write to the requested register
        bank[7] = 32'h11111111;
        wr_en   = 1'b1;
        wr_addr = 7;
        wr_data = 32'h22222222;
        request(7);
        wr_en     = 1'b0;
        req_valid = 1'b0;
        step();
`ifdef REGREAD_BYPASS_EN
        chk("bypass_data", {32'd0, last.data}, 64'h22222222);
`else
        chk("bypass_data", {32'd0, last.data}, 64'h11111111);
`endif

        // Back-to-back stream 1..8 with no bubbles
        for (int i = 1; i <= 8; i++) bank[i] = 32'h01010101 * i;
        pops0 = n_pops;
        for (int i = 1; i <= 8; i++) request(REG_ADDR_W'(i));
        req_valid = 1'b0;
        step();
        chk("stream_pops", 64'(n_pops - pops0), 64'd8);

        // Asynchronous reset with two entries buffered
        rsp_ready = 1'b0;
        request(9);
        request(10);
        req_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("arst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("arst_rsp_data",  {32'd0, rsp_data},  64'd0);
        q.delete();
        last = '0;
        #2;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < REG_COUNT; i++) bank[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = REG_ADDR_W'($urandom_range(0, REG_COUNT - 1));
            rsp_ready = ($urandom_range(0, 2) != 0);
            wr_en     = ($urandom_range(0, 1) != 0);
            wr_addr   = ($urandom_range(0, 2) == 0) ? req_addr : REG_ADDR_W'($urandom_range(0, REG_COUNT - 1));
            wr_data   = $urandom;
            step();
        end
        wr_en     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
